// File: rtl/ed25519_pkg.sv
// Shared constants and types for the GF(2^255-19) field-multiply responder.
// P is the field prime. The FSM state type is shared so that the design and any checker agree on its encoding.
package ed25519_pkg;

   localparam int unsigned FE_W = 256;

   localparam logic [255:0] P =
      256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

   localparam logic [7:0] CNT_TOP = 8'd255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/fe_mul_resp_if.sv
// Request/response bundle for fe_mul_resp: a valid/ready request channel carrying two
// operands, and a valid/ready response channel carrying the product mod p.
interface fe_mul_resp_if;

   logic         req_valid;
   logic         req_ready;
   logic [255:0] a;
   logic [255:0] b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [255:0] rsp_data;
   logic         busy;

   modport master (
      output req_valid, a, b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, busy
   );

   modport slave (
      input  req_valid, a, b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, busy
   );

endinterface

// File: rtl/fe_cond_sub.sv
// Single conditional subtraction of p: y = x - p when x >= p, otherwise x.
// For any x < 2p the result lands in 0..p-1.
module fe_cond_sub
   import ed25519_pkg::*;
(
   input  logic [256:0] x,
   output logic [256:0] y
);

   logic [257:0] diff_s;

   // Subtract p one bit wider so the top bit is the borrow flag.
   always_comb begin
      diff_s = {1'b0, x} - {2'b00, P};
      if (diff_s[257]) begin
         y = x;
      end else begin
         y = diff_s[256:0];
      end
   end

endmodule

// File: rtl/fe_mul_resp.sv
// Bit-serial modular multiplier: (a*b) mod (2^255-19) by MSB-first double-and-add.
// One multiplier bit is processed per cycle, using 257-bit intermediates.
module fe_mul_resp
   import ed25519_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   fe_mul_resp_if.slave bus
);

   state_e       state_q, state_d;
   logic [256:0] a_q, a_d;
   logic [255:0] b_q, b_d;
   logic [256:0] acc_q, acc_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [255:0] rsp_data_q, rsp_data_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic         req_ready_q, req_ready_d;
   logic         busy_q, busy_d;

   logic [256:0] red0_s, red1_s;
   logic [256:0] dbl_in_s, dbl_s;
   logic [256:0] add_in_s, add_s;
   logic [256:0] step_s;

   // A raw operand can reach 2^256-1 = 2p+37, so two chained subtractions are needed.
   fe_cond_sub u_red0 (.x(a_q),    .y(red0_s));
   fe_cond_sub u_red1 (.x(red0_s), .y(red1_s));

   assign dbl_in_s = acc_q << 1'b1;
   fe_cond_sub u_dbl (.x(dbl_in_s), .y(dbl_s));

   assign add_in_s = dbl_s + a_q;
   fe_cond_sub u_add (.x(add_in_s), .y(add_s));

   // Next-state and datapath selection for the IDLE/LOAD/MUL/DONE sequencer.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      step_s     = b_q[cnt_q] ? add_s : dbl_s;

      case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               a_d     = {1'b0, bus.a};
               b_d     = bus.b;
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            a_d   = red1_s;
            acc_d = 257'd0;
            cnt_d = CNT_TOP;
            if (EARLY_EXIT && ((red1_s == 257'd0) || (b_q == 256'd0))) begin
               rsp_data_d = 256'd0;
               state_d    = DONE;
            end else begin
               state_d    = MUL;
            end
         end
         MUL: begin
            acc_d = step_s;
            if (cnt_q == 8'd0) begin
               rsp_data_d = step_s[255:0];
               state_d    = DONE;
            end else begin
               cnt_d      = cnt_q - 8'd1;
            end
         end
         DONE: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      rsp_valid_d = (state_d == DONE);
   end

   // State, datapath and output registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= 257'd0;
         b_q         <= 256'd0;
         acc_q       <= 257'd0;
         cnt_q       <= 8'd0;
         rsp_data_q  <= 256'd0;
         rsp_valid_q <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.busy      = busy_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fe_mul_resp.sv
// Directed bench for fe_mul_resp: known products, latency, back-pressure, mid-operation reset,
// and a short back-to-back random run checked against a wide-arithmetic reference.
module tb_fe_mul_resp;

   localparam logic [255:0] P_TB =
      256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
   localparam logic [255:0] PM1 =
      256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffec;
   localparam logic [255:0] TWO255 =
      256'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000;
   localparam logic [255:0] ALL1 =
      256'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff;
   localparam int RN = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   lat;

   fe_mul_resp_if if_ee ();
   fe_mul_resp_if if_ne ();

   fe_mul_resp #(.EARLY_EXIT(1'b1)) u_dut_ee (.clk(clk), .rst_n(rst_n), .bus(if_ee.slave));
   fe_mul_resp #(.EARLY_EXIT(1'b0)) u_dut_ne (.clk(clk), .rst_n(rst_n), .bus(if_ne.slave));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
      logic [511:0] prod;
      logic [511:0] rem;
      prod = {256'd0, x} * {256'd0, y};
      rem  = prod % {256'd0, P_TB};
      return rem[255:0];
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic wait_rsp_ee();
      lat = 0;
      while (if_ee.rsp_valid !== 1'b1 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // fast=1: an early-exit result is expected to be valid by edge k+2
   task automatic run_op(input string tag, input logic [255:0] av, input logic [255:0] bv,
                         input logic [255:0] ev, input bit fast);
      @(negedge clk);
      check_val({tag, "_rdy"}, {255'd0, if_ee.req_ready}, 256'd1);
      if_ee.req_valid = 1'b1;
      if_ee.a         = av;
      if_ee.b         = bv;
      if_ee.rsp_ready = 1'b0;
      @(negedge clk);
      if_ee.req_valid = 1'b0;
      if_ee.a         = ~av;
      if_ee.b         = ~bv;
      wait_rsp_ee();
      if (fast) check_val({tag, "_lat"}, {255'd0, (lat <= 2)}, 256'd1);
      else      check_val({tag, "_lat"}, 256'(lat), 256'd257);
      check_val({tag, "_data"}, if_ee.rsp_data, ev);
      if_ee.rsp_ready = 1'b1;
      @(negedge clk);
      if_ee.rsp_ready = 1'b0;
      check_val({tag, "_done"}, {255'd0, if_ee.rsp_valid}, 256'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] exp_q[$];
      logic [255:0] ev;
      int           got_n, issued, last_t;
      bit           chg;

      if_ee.req_valid = 1'b0; if_ee.a = 256'd0; if_ee.b = 256'd0; if_ee.rsp_ready = 1'b0;
      if_ne.req_valid = 1'b0; if_ne.a = 256'd0; if_ne.b = 256'd0; if_ne.rsp_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_ready", {255'd0, if_ee.req_ready}, 256'd1);
      check_val("rst_busy",  {255'd0, if_ee.busy},      256'd0);
      check_val("rst_valid", {255'd0, if_ee.rsp_valid}, 256'd0);
      check_val("rst_data",  if_ee.rsp_data,            256'd0);
      check_val("rst_ne_rdy", {255'd0, if_ne.req_ready}, 256'd1);
      rst_n = 1'b1;

      run_op("mul_2x3",   256'd2, 256'd3, 256'd6,  1'b0);
      run_op("mul_pm1sq", PM1,    PM1,    256'd1,  1'b0);
      run_op("mul_2p255", TWO255, 256'd1, 256'd19, 1'b0);
      run_op("mul_all1",  ALL1,   256'd1, 256'd37, 1'b0);
      run_op("ee_a0",     256'd0, 256'd5, 256'd0,  1'b1);
      run_op("ee_b0",     256'd9, 256'd0, 256'd0,  1'b1);
      run_op("ee_ap",     P_TB,   256'd7, 256'd0,  1'b1);

      // Same zero operand on the instance without early exit
      @(negedge clk);
      if_ne.req_valid = 1'b1; if_ne.a = 256'd0; if_ne.b = 256'd5;
      @(negedge clk);
      if_ne.req_valid = 1'b0;
      lat = 0;
      while (if_ne.rsp_valid !== 1'b1 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      check_val("ne_a0_lat",  256'(lat), 256'd257);
      check_val("ne_a0_data", if_ne.rsp_data, 256'd0);
      if_ne.rsp_ready = 1'b1;
      @(negedge clk);
      if_ne.rsp_ready = 1'b0;

      // Back-pressure with a new request held pending throughout
      @(negedge clk);
      if_ee.req_valid = 1'b1; if_ee.a = 256'd3; if_ee.b = 256'd5; if_ee.rsp_ready = 1'b0;
      @(negedge clk);
      if_ee.a = 256'd4; if_ee.b = 256'd6;
      wait_rsp_ee();
      check_val("bp_lat",  256'(lat), 256'd257);
      check_val("bp_data", if_ee.rsp_data, 256'd15);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_val("bp_hold_data",  if_ee.rsp_data, 256'd15);
         check_val("bp_hold_ready", {255'd0, if_ee.req_ready}, 256'd0);
         check_val("bp_hold_valid", {255'd0, if_ee.rsp_valid}, 256'd1);
      end
      if_ee.rsp_ready = 1'b1;
      @(negedge clk);
      if_ee.rsp_ready = 1'b0;
      check_val("bp_idle_ready", {255'd0, if_ee.req_ready}, 256'd1);
      check_val("bp_idle_busy",  {255'd0, if_ee.busy},      256'd0);
      @(negedge clk);
      if_ee.req_valid = 1'b0;
      check_val("bp_next_busy", {255'd0, if_ee.busy}, 256'd1);
      wait_rsp_ee();
      check_val("bp_next_lat",  256'(lat), 256'd257);
      check_val("bp_next_data", if_ee.rsp_data, 256'd24);
      if_ee.rsp_ready = 1'b1;
      @(negedge clk);
      if_ee.rsp_ready = 1'b0;

      // Reset about 100 cycles into MUL
      @(negedge clk);
      if_ee.req_valid = 1'b1; if_ee.a = 256'd123; if_ee.b = 256'd456;
      @(negedge clk);
      if_ee.req_valid = 1'b0;
      repeat (101) @(negedge clk);
      check_val("mid_busy", {255'd0, if_ee.busy}, 256'd1);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_ready", {255'd0, if_ee.req_ready}, 256'd1);
      check_val("mid_rst_busy",  {255'd0, if_ee.busy},      256'd0);
      check_val("mid_rst_valid", {255'd0, if_ee.rsp_valid}, 256'd0);
      check_val("mid_rst_data",  if_ee.rsp_data,            256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_val("post_rst_valid", {255'd0, if_ee.rsp_valid}, 256'd0);
      check_val("post_rst_ready", {255'd0, if_ee.req_ready}, 256'd1);
      run_op("mul_7x11", 256'd7, 256'd11, 256'd77, 1'b0);

      // Back-to-back random operations, consumer always ready
      @(negedge clk);
      if_ee.rsp_ready = 1'b1;
      if_ee.req_valid = 1'b1;
      if_ee.a = rand256();
      if_ee.b = rand256();
      chg = 1'b0; got_n = 0; issued = 0; last_t = -1;
      for (int cyc = 0; cyc < RN*259 + 600 && got_n < RN; cyc++) begin
         if (if_ee.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check_val("rnd_extra", 256'd1, 256'd0);
            end else begin
               ev = exp_q.pop_front();
               check_val("rnd_data", if_ee.rsp_data, ev);
            end
            if (last_t >= 0) check_val("rnd_thru", 256'(cyc - last_t), 256'd259);
            last_t = cyc;
            got_n++;
         end
         if (chg) begin
            if_ee.a = rand256();
            if_ee.b = rand256();
            if (issued >= RN) if_ee.req_valid = 1'b0;
            chg = 1'b0;
         end
         if (if_ee.req_ready === 1'b1 && if_ee.req_valid === 1'b1) begin
            exp_q.push_back(ref_mul(if_ee.a, if_ee.b));
            issued++;
            chg = 1'b1;
         end
         @(negedge clk);
      end
      check_val("rnd_count", 256'(got_n), 256'(RN));
      if_ee.req_valid = 1'b0;
      if_ee.rsp_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
